// File: rtl/rv_writeback.sv
// rv_writeback: register-file writeback stage with load formatting, wait
// states, load timeout and misaligned-load detection.
module rv_writeback #(
    parameter int G_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  x_fun_i,
    input  logic        x_load_i,
    input  logic        x_store_i,
    input  logic [4:0]  x_rd_i,
    input  logic [31:0] x_rd_value_i,
    input  logic        x_rd_write_i,
    input  logic [31:0] x_dm_addr_i,
    input  logic [31:0] dm_data_l_i,
    input  logic        dm_load_done_i,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_rd_value_o,
    output logic        rf_rd_write_o,
    output logic        w_stall_req_o,
    output logic        w_bus_err_o,
    output logic        w_misaligned_o
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;
    localparam logic [7:0] CNT_LAST = 8'(G_TIMEOUT - 1);

    logic [0:0] state;
    logic [7:0] cnt;
    logic [4:0] cap_rd;
    logic       cap_wr;
    logic [2:0] cap_fun;
    logic [1:0] cap_addr;

    logic       aligned;
    logic       cnt_last;
    logic       unused_addr;

    // Only the byte offset of the address matters to this stage.
    assign unused_addr = ^x_dm_addr_i[31:2];

    function automatic logic fun_valid(input logic [2:0] f);
        return (f == 3'b000) || (f == 3'b001) || (f == 3'b010) ||
               (f == 3'b100) || (f == 3'b101);
    endfunction

    // Halfword loads need an even address, word loads a word-aligned one.
    function automatic logic is_misaligned(input logic [2:0] f, input logic [1:0] a);
        return ((f[1:0] == 2'b01) && a[0]) || ((f == 3'b010) && (a != 2'b00));
    endfunction

    function automatic logic [31:0] fmt(input logic [2:0] f, input logic [1:0] a,
                                        input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{a, 3'b000} +: 8];
        h = a[1] ? d[31:16] : d[15:0];
        case (f)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b010:  return d;
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return 32'd0;
        endcase
    endfunction

    assign aligned  = !is_misaligned(x_fun_i, x_dm_addr_i[1:0]);
    assign cnt_last = (cnt == CNT_LAST);

    // Stall while a load is outstanding and not about to complete or time out.
    always_comb begin
        w_stall_req_o = 1'b0;
        if (state == S_IDLE)
            w_stall_req_o = x_load_i && !dm_load_done_i && aligned;
        else
            w_stall_req_o = !dm_load_done_i && !cnt_last;
    end

    // Writeback state machine; write/error/misaligned strobes are one-cycle pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= S_IDLE;
            cnt            <= 8'd0;
            cap_rd         <= 5'd0;
            cap_wr         <= 1'b0;
            cap_fun        <= 3'd0;
            cap_addr       <= 2'd0;
            rf_rd_o        <= 5'd0;
            rf_rd_value_o  <= 32'd0;
            rf_rd_write_o  <= 1'b0;
            w_bus_err_o    <= 1'b0;
            w_misaligned_o <= 1'b0;
        end else begin
            rf_rd_write_o  <= 1'b0;
            w_bus_err_o    <= 1'b0;
            w_misaligned_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (x_load_i) begin
                        if (!aligned) begin
                            w_misaligned_o <= 1'b1;
                        end else if (dm_load_done_i) begin
                            rf_rd_o       <= x_rd_i;
                            rf_rd_value_o <= fmt(x_fun_i, x_dm_addr_i[1:0], dm_data_l_i);
                            rf_rd_write_o <= x_rd_write_i && (x_rd_i != 5'd0) && fun_valid(x_fun_i);
                        end else begin
                            cap_rd   <= x_rd_i;
                            cap_wr   <= x_rd_write_i;
                            cap_fun  <= x_fun_i;
                            cap_addr <= x_dm_addr_i[1:0];
                            cnt      <= 8'd0;
                            state    <= S_WAIT;
                        end
                    end else if (!x_store_i && x_rd_write_i) begin
                        // ALU/shifter result; r0 updates the bus but never writes.
                        rf_rd_o       <= x_rd_i;
                        rf_rd_value_o <= x_rd_value_i;
                        rf_rd_write_o <= (x_rd_i != 5'd0);
                    end
                end
                default: begin
                    if (dm_load_done_i) begin
                        rf_rd_o       <= cap_rd;
                        rf_rd_value_o <= fmt(cap_fun, cap_addr, dm_data_l_i);
                        rf_rd_write_o <= cap_wr && (cap_rd != 5'd0) && fun_valid(cap_fun);
                        state         <= S_IDLE;
                    end else if (cnt_last) begin
                        w_bus_err_o <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_writeback.sv
// tb_rv_writeback: directed scenarios plus a randomized run against a
// behavioural model of the writeback stage.
module tb_rv_writeback;

    localparam int G = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  x_fun;
    logic        x_load, x_store, x_rd_write, dm_done;
    logic [4:0]  x_rd;
    logic [31:0] x_rd_value, x_addr, dm_data;
    logic [4:0]  rf_rd;
    logic [31:0] rf_val;
    logic        rf_wr, stall, bus_err, misal;

    int checks = 0;
    int fails  = 0;

    // behavioural model state
    bit          m_pending;
    int          m_waited;
    int unsigned m_cap_rd, m_cap_fun, m_cap_a;
    bit          m_cap_wr;
    int unsigned m_rd, m_val;
    bit          m_wr, m_err, m_mis;

    rv_writeback #(.G_TIMEOUT(G)) dut (
        .clk_i(clk), .rst_i(rst),
        .x_fun_i(x_fun), .x_load_i(x_load), .x_store_i(x_store),
        .x_rd_i(x_rd), .x_rd_value_i(x_rd_value), .x_rd_write_i(x_rd_write),
        .x_dm_addr_i(x_addr), .dm_data_l_i(dm_data), .dm_load_done_i(dm_done),
        .rf_rd_o(rf_rd), .rf_rd_value_o(rf_val), .rf_rd_write_o(rf_wr),
        .w_stall_req_o(stall), .w_bus_err_o(bus_err), .w_misaligned_o(misal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        x_fun = 3'd0; x_load = 0; x_store = 0; x_rd = 0; x_rd_value = 0;
        x_rd_write = 0; x_addr = 0; dm_data = 0; dm_done = 0;
    endtask

    function automatic bit m_valid(int unsigned f);
        return f == 0 || f == 1 || f == 2 || f == 4 || f == 5;
    endfunction

    function automatic bit m_misaligned(int unsigned f, int unsigned a);
        return ((f == 1 || f == 5) && (a % 2 != 0)) || (f == 2 && a != 0);
    endfunction

    function automatic int unsigned m_format(int unsigned f, int unsigned a, int unsigned d);
        int unsigned bv, hv;
        bv = (d >> (8 * a)) & 32'hFF;
        hv = (d >> (16 * (a / 2))) & 32'hFFFF;
        case (f)
            0: return (bv >= 128) ? bv + 32'hFFFF_FF00 : bv;
            1: return (hv >= 32768) ? hv + 32'hFFFF_0000 : hv;
            2: return d;
            4: return bv;
            5: return hv;
            default: return 0;
        endcase
    endfunction

    function automatic bit m_stall();
        if (m_pending) return !dm_done && (m_waited < G - 1);
        return x_load && !dm_done && !m_misaligned(x_fun, x_addr[1:0]);
    endfunction

    // Advance the model by one clock edge using the current inputs.
    task automatic m_step();
        m_wr = 0; m_err = 0; m_mis = 0;
        if (m_pending) begin
            if (dm_done) begin
                m_pending = 0;
                m_rd  = m_cap_rd;
                m_val = m_format(m_cap_fun, m_cap_a, dm_data);
                m_wr  = m_cap_wr && m_cap_rd != 0 && m_valid(m_cap_fun);
            end else if (m_waited == G - 1) begin
                m_pending = 0;
                m_err = 1;
            end else begin
                m_waited++;
            end
        end else if (x_load) begin
            if (m_misaligned(x_fun, x_addr[1:0])) begin
                m_mis = 1;
            end else if (dm_done) begin
                m_rd  = x_rd;
                m_val = m_format(x_fun, x_addr[1:0], dm_data);
                m_wr  = x_rd_write && x_rd != 0 && m_valid(x_fun);
            end else begin
                m_pending = 1; m_waited = 0;
                m_cap_rd = x_rd; m_cap_wr = x_rd_write; m_cap_fun = x_fun; m_cap_a = x_addr[1:0];
            end
        end else if (!x_store && x_rd_write) begin
            m_rd = x_rd; m_val = x_rd_value; m_wr = (x_rd != 0);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        #2 rst = 1;
        #1;
        checks++;
        if ({rf_rd, rf_val, rf_wr, bus_err, misal, stall} !== '0) begin
            fails++; $display("FAIL reset_async: got rd=%0d val=%h wr=%b err=%b mis=%b stall=%b, want all 0",
                              rf_rd, rf_val, rf_wr, bus_err, misal, stall);
        end
        @(negedge clk) rst = 0;
        tick();
        checks++;
        if ({rf_rd, rf_val, rf_wr, bus_err, misal, stall} !== '0) begin
            fails++; $display("FAIL reset_release: got rd=%0d val=%h wr=%b, want all 0", rf_rd, rf_val, rf_wr);
        end
    endtask

    task automatic test_alu_write();
        x_rd_write = 1; x_rd = 5; x_rd_value = 32'h1234;
        tick();
        checks++;
        if ({rf_wr, rf_rd, rf_val} !== {1'b1, 5'd5, 32'h1234}) begin
            fails++; $display("FAIL alu_write: got wr=%b rd=%0d val=%h, want 1/5/00001234", rf_wr, rf_rd, rf_val);
        end
        x_rd = 0;
        tick();
        checks++;
        if (rf_wr !== 1'b0) begin
            fails++; $display("FAIL alu_r0: got wr=%b want 0", rf_wr);
        end
        x_rd_write = 0; x_rd = 9; x_rd_value = 32'hDEAD;
        tick();
        checks++;
        if ({rf_wr, rf_val} !== {1'b0, 32'h1234}) begin
            fails++; $display("FAIL idle_hold: got wr=%b val=%h, want 0/00001234", rf_wr, rf_val);
        end
        x_store = 1; x_rd_write = 1; x_rd = 6;
        tick();
        checks++;
        if (rf_wr !== 1'b0) begin
            fails++; $display("FAIL store_no_write: got wr=%b want 0", rf_wr);
        end
        idle_inputs();
    endtask

    task automatic test_zero_wait_lb();
        x_load = 1; x_fun = 3'b000; x_addr = 32'h103; dm_data = 32'h80FF_FFFF;
        dm_done = 1; x_rd = 7; x_rd_write = 1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            fails++; $display("FAIL lb_stall: got %b want 0", stall);
        end
        tick();
        checks++;
        if ({rf_wr, rf_rd, rf_val} !== {1'b1, 5'd7, 32'hFFFF_FF80}) begin
            fails++; $display("FAIL lb_value: got wr=%b rd=%0d val=%h want 1/7/ffffff80", rf_wr, rf_rd, rf_val);
        end
        x_fun = 3'b100;
        tick();
        checks++;
        if ({rf_wr, rf_val} !== {1'b1, 32'h0000_0080}) begin
            fails++; $display("FAIL lbu_value: got wr=%b val=%h want 1/00000080", rf_wr, rf_val);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_wait_lhu();
        int n_stall = 0, n_wr = 0;
        logic [31:0] wval = 0;
        logic [4:0]  wrd = 0;
        x_load = 1; x_fun = 3'b101; x_addr = 32'h202; x_rd = 9; x_rd_write = 1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                // garbage on x_* while waiting must be ignored
                x_load = 0; x_rd = 3; x_rd_value = 32'h5555; x_store = 0;
            end
            dm_done = (i == 3);
            dm_data = (i == 3) ? 32'hBEEF_0000 : 32'h1111_1111;
            #1;
            if (stall) n_stall++;
            tick();
            if (rf_wr) begin n_wr++; wval = rf_val; wrd = rf_rd; end
            if (i == 3) idle_inputs();
        end
        checks++;
        if (n_stall != 3) begin
            fails++; $display("FAIL lhu_stall_cycles: got %0d want 3", n_stall);
        end
        checks++;
        if (n_wr != 1 || wval !== 32'h0000_BEEF || wrd !== 5'd9) begin
            fails++; $display("FAIL lhu_write: got n=%0d rd=%0d val=%h want 1/9/0000beef", n_wr, wrd, wval);
        end
    endtask

    task automatic test_timeout();
        int n_wait_stall = 0, n_err = 0, n_wr = 0;
        x_load = 1; x_fun = 3'b010; x_addr = 32'h100; x_rd = 12; x_rd_write = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (i > 0 && stall) n_wait_stall++;
            tick();
            if (bus_err) n_err++;
            if (rf_wr) n_wr++;
            idle_inputs();
        end
        checks++;
        if (n_wait_stall != G - 1) begin
            fails++; $display("FAIL timeout_stall: got %0d want %0d", n_wait_stall, G - 1);
        end
        checks++;
        if (n_err != 1 || n_wr != 0) begin
            fails++; $display("FAIL timeout_pulse: got err=%0d wr=%0d want 1/0", n_err, n_wr);
        end
        x_rd_write = 1; x_rd = 2; x_rd_value = 32'hA5;
        tick();
        checks++;
        if ({rf_wr, rf_rd, rf_val} !== {1'b1, 5'd2, 32'hA5}) begin
            fails++; $display("FAIL timeout_idle: got wr=%b rd=%0d val=%h want 1/2/000000a5", rf_wr, rf_rd, rf_val);
        end
        idle_inputs();
    endtask

    task automatic test_misaligned();
        x_load = 1; x_fun = 3'b010; x_addr = 32'h2; x_rd = 4; x_rd_write = 1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            fails++; $display("FAIL misal_stall: got %b want 0", stall);
        end
        tick();
        checks++;
        if ({misal, rf_wr} !== 2'b10) begin
            fails++; $display("FAIL misal_pulse: got mis=%b wr=%b want 1/0", misal, rf_wr);
        end
        idle_inputs();
        tick();
        checks++;
        if ({misal, rf_wr, stall} !== 3'b000) begin
            fails++; $display("FAIL misal_single: got mis=%b wr=%b stall=%b want 0/0/0", misal, rf_wr, stall);
        end
    endtask

    task automatic test_reset_wait();
        x_load = 1; x_fun = 3'b010; x_addr = 32'h40; x_rd = 8; x_rd_write = 1;
        tick();
        idle_inputs();
        tick();
        checks++;
        if (stall !== 1'b1) begin
            fails++; $display("FAIL rstwait_pre: got stall=%b want 1", stall);
        end
        rst = 1;
        #1;
        checks++;
        if ({rf_rd, rf_val, rf_wr, bus_err, misal, stall} !== '0) begin
            fails++; $display("FAIL rstwait_clear: got rd=%0d val=%h wr=%b stall=%b want all 0", rf_rd, rf_val, rf_wr, stall);
        end
        @(negedge clk) rst = 0;
        dm_done = 1; dm_data = 32'hCAFE_F00D;
        tick();
        idle_inputs();
        tick();
        checks++;
        if ({rf_wr, bus_err} !== 2'b00) begin
            fails++; $display("FAIL rstwait_late_done: got wr=%b err=%b want 0/0", rf_wr, bus_err);
        end
    endtask

    task automatic test_random();
        bit exp_stall;
        idle_inputs();
        @(negedge clk) rst = 1;
        @(negedge clk) rst = 0;
        m_pending = 0; m_waited = 0; m_cap_rd = 0; m_cap_wr = 0; m_cap_fun = 0; m_cap_a = 0;
        m_rd = 0; m_val = 0; m_wr = 0; m_err = 0; m_mis = 0;
        tick();
        for (int i = 0; i < 3000; i++) begin
            x_load     = ($urandom_range(0, 2) == 0);
            x_store    = !x_load && ($urandom_range(0, 4) == 0);
            x_fun      = 3'($urandom);
            x_rd       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            x_rd_write = ($urandom_range(0, 3) != 0);
            x_rd_value = $urandom;
            x_addr     = $urandom;
            dm_data    = $urandom;
            dm_done    = ($urandom_range(0, 3) == 0);
            #1;
            exp_stall = m_stall();
            checks++;
            if (stall !== exp_stall) begin
                fails++; $display("FAIL rand_stall @%0d: got %b want %b", i, stall, exp_stall);
            end
            m_step();
            tick();
            checks++;
            if (rf_wr !== m_wr || rf_rd !== 5'(m_rd) || rf_val !== m_val ||
                bus_err !== m_err || misal !== m_mis) begin
                fails++; $display("FAIL rand_out @%0d: got wr=%b rd=%0d val=%h err=%b mis=%b want %b/%0d/%h/%b/%b",
                                  i, rf_wr, rf_rd, rf_val, bus_err, misal, m_wr, m_rd, m_val, m_err, m_mis);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_zero_wait_lb();
        test_wait_lhu();
        test_timeout();
        test_misaligned();
        test_reset_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
